// File: rtl/sha256_block_sequencer.sv
// SHA-256 block sequencer: hands padded 512-bit blocks to an external compression
// core, folds each result into the chaining value and presents the final digest.
module sha256_block_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [16*DATA_WIDTH-1:0] s_block,
    input  logic                     s_last,
    input  logic                     i_abort,
    output logic                     core_load,
    output logic [16*DATA_WIDTH-1:0] core_msg,
    output logic [8*DATA_WIDTH-1:0]  core_h_in,
    input  logic [8*DATA_WIDTH-1:0]  core_h_out,
    input  logic                     core_valid,
    output logic [8*DATA_WIDTH-1:0]  o_digest,
    output logic                     o_digest_valid,
    input  logic                     o_digest_ready,
    output logic [15:0]              o_block_cnt,
    output logic                     o_error
);

    localparam int BLK_W   = 16 * DATA_WIDTH;
    localparam int HASH_W  = 8 * DATA_WIDTH;
    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [255:0] IV_ALL = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        ACC,
        DONE,
        ERR
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [BLK_W-1:0]     block_reg;
    logic                 last_reg;
    logic                 first_reg;
    logic [15:0]          cnt_reg;
    logic [TIMER_W-1:0]   timer_reg;
    logic [HASH_W-1:0]    h_all;
    logic                 accept;

    // Abort wins over everything, including an acceptance in IDLE.
    assign accept = (state_reg == IDLE) && s_valid && !i_abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        s_ready        = 1'b0;
        core_load      = 1'b0;
        o_digest_valid = 1'b0;
        o_error        = 1'b0;
        case (state_reg)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                core_load  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A result on the final timer cycle is still taken.
                if (core_valid) begin
                    state_next = ACC;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = ERR;
                end
            end
            ACC: begin
                state_next = last_reg ? DONE : IDLE;
            end
            DONE: begin
                o_digest_valid = 1'b1;
                if (o_digest_ready) begin
                    state_next = IDLE;
                end
            end
            ERR: begin
                o_error = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (i_abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_reg <= 1'b1;
            cnt_reg   <= '0;
            timer_reg <= '0;
            last_reg  <= 1'b0;
        end else if (i_abort) begin
            first_reg <= 1'b1;
            cnt_reg   <= '0;
            timer_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        last_reg <= s_last;
                        if (first_reg) begin
                            cnt_reg <= '0;
                        end
                    end
                end
                LOAD: timer_reg <= '0;
                WAIT: timer_reg <= timer_reg + TIMER_W'(1);
                ACC: begin
                    cnt_reg   <= cnt_reg + 16'd1;
                    first_reg <= 1'b0;
                end
                DONE: begin
                    if (o_digest_ready) begin
                        first_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The message block is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            block_reg <= s_block;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_word
            localparam int MSB = HASH_W - 1 - gi * DATA_WIDTH;
            localparam logic [DATA_WIDTH-1:0] IV_WORD = DATA_WIDTH'(IV_ALL[255 - 32*gi -: 32]);

            logic [DATA_WIDTH-1:0] h_word_reg;
            logic [DATA_WIDTH-1:0] out_word_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    h_word_reg   <= IV_WORD;
                    out_word_reg <= '0;
                end else if (!i_abort) begin
                    if (accept && first_reg) begin
                        h_word_reg <= IV_WORD;
                    end else if (state_reg == ACC) begin
                        h_word_reg <= h_word_reg + out_word_reg;
                    end
                    if ((state_reg == WAIT) && core_valid) begin
                        out_word_reg <= core_h_out[MSB -: DATA_WIDTH];
                    end
                end
            end

            assign h_all[MSB -: DATA_WIDTH] = h_word_reg;
        end
    endgenerate

    assign core_msg    = block_reg;
    assign core_h_in   = h_all;
    assign o_digest    = h_all;
    assign o_block_cnt = cnt_reg;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Bench for sha256_block_sequencer: a behavioural SHA-256 core model answers each
// core_load, and whole-message digests come from a reference hash over padded blocks.
module tb_sha256_block_sequencer;

    localparam int DW = 32;
    localparam int TO = 128;
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DIGEST = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [511:0] s_block = '0;
    logic         s_last = 1'b0;
    logic         i_abort = 1'b0;
    logic         core_load;
    logic [511:0] core_msg;
    logic [255:0] core_h_in;
    logic [255:0] core_h_out;
    logic         core_valid;
    logic [255:0] o_digest;
    logic         o_digest_valid;
    logic         o_digest_ready = 1'b1;
    logic [15:0]  o_block_cnt;
    logic         o_error;

    int errors = 0;
    int checks = 0;

    // Core model state; manual_* lets a test inject a stray core_valid pulse.
    logic         model_enable = 1'b1;
    logic         model_flush = 1'b0;
    logic         model_valid = 1'b0;
    logic         model_pending = 1'b0;
    int           model_lat = 66;
    int           model_wait = 0;
    logic [255:0] model_res = '0;
    logic [255:0] model_out = '0;
    logic         manual_valid = 1'b0;
    logic [255:0] manual_out = '0;

    byte unsigned msg_bytes[$];
    logic [511:0] msg_q[$];

    assign core_valid = model_valid | manual_valid;
    assign core_h_out = manual_valid ? manual_out : model_out;

    always #5 clk = ~clk;

    sha256_block_sequencer #(
        .DATA_WIDTH(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_block(s_block),
        .s_last(s_last),
        .i_abort(i_abort),
        .core_load(core_load),
        .core_msg(core_msg),
        .core_h_in(core_h_in),
        .core_h_out(core_h_out),
        .core_valid(core_valid),
        .o_digest(o_digest),
        .o_digest_valid(o_digest_valid),
        .o_digest_ready(o_digest_ready),
        .o_block_cnt(o_block_cnt),
        .o_error(o_error)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One SHA-256 compression: returns the final working variables a..h.
    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a, b, c, d, e, f, g, hh};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] h, input logic [255:0] o);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[255 - 32*k -: 32] = h[255 - 32*k -: 32] + o[255 - 32*k -: 32];
        return r;
    endfunction

    function automatic logic [255:0] ref_digest();
        logic [255:0] h;
        h = IV;
        foreach (msg_q[i]) h = add8(h, sha_compress(h, msg_q[i]));
        return h;
    endfunction

    function automatic void set_string(input string s);
        msg_bytes.delete();
        for (int i = 0; i < s.len(); i++) msg_bytes.push_back(s[i]);
    endfunction

    function automatic void build_blocks();
        byte unsigned p[$];
        longint unsigned bits;
        logic [511:0] blk;
        p = msg_bytes;
        bits = 64'(msg_bytes.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8*i)));
        msg_q.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
            msg_q.push_back(blk);
        end
    endfunction

    // Core model: answers core_load with one core_valid pulse model_lat cycles later.
    initial begin
        forever begin
            @(negedge clk);
            model_valid = 1'b0;
            if (model_flush) begin
                model_pending = 1'b0;
            end else if (model_pending) begin
                model_wait = model_wait - 1;
                if (model_wait == 0) begin
                    model_pending = 1'b0;
                    model_out = model_res;
                    model_valid = 1'b1;
                end
            end else if (core_load && model_enable) begin
                model_res = sha_compress(core_h_in, core_msg);
                model_wait = model_lat;
                model_pending = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_block(input logic [511:0] blk, input logic last);
        bit ok;
        ok = 1'b0;
        s_block = blk;
        s_last = last;
        s_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_wait: s_ready=%b required 1 within 2000 cycles", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (core_load !== 1'b1) begin
            errors++;
            $display("FAIL load_latency: core_load=%b required 1 one cycle after accept", core_load);
        end
    endtask

    task automatic wait_digest(input logic [255:0] exp, input int exp_cnt, input string name, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 1000; i++) begin
            if (o_digest_valid) begin
                ok = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_valid: o_digest_valid=%b required 1 within 1000 cycles", name, o_digest_valid);
        end
        checks++;
        if (o_digest !== exp) begin
            errors++;
            $display("FAIL %s_digest: got %h required %h", name, o_digest, exp);
        end
        checks++;
        if (o_block_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL %s_block_cnt: got %0d required %0d", name, o_block_cnt, exp_cnt);
        end
        $display("digest %s: %h blocks=%0d", name, o_digest, o_block_cnt);
        @(negedge clk);
    endtask

    task automatic send_message();
        foreach (msg_q[i]) send_block(msg_q[i], (i == msg_q.size() - 1));
    endtask

    task automatic check_idle_clean(input string name, input logic [255:0] exp_h);
        checks++;
        if ({s_ready, core_load, o_digest_valid, o_error} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_ctrl: ready/load/valid/error=%b%b%b%b required 1000",
                     name, s_ready, core_load, o_digest_valid, o_error);
        end
        checks++;
        if (o_block_cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s_cnt: got %0d required 0", name, o_block_cnt);
        end
        checks++;
        if (o_digest !== exp_h) begin
            errors++;
            $display("FAIL %s_h: got %h required %h", name, o_digest, exp_h);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_clean("reset", IV);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs idle, H=IV");
    endtask

    task automatic test_abc();
        int waited;
        set_string("abc");
        build_blocks();
        model_lat = 66;
        send_message();
        wait_digest(ABC_DIGEST, 1, "abc", waited);
        // valid pulse at lat, ACC the cycle after, DONE one cycle later
        checks++;
        if (waited !== 68) begin
            errors++;
            $display("FAIL abc_latency: digest after %0d cycles required 68", waited);
        end
    endtask

    task automatic test_two_block();
        int waited;
        logic [255:0] h1;
        set_string("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        build_blocks();
        h1 = add8(IV, sha_compress(IV, msg_q[0]));
        send_block(msg_q[0], 1'b0);
        send_block(msg_q[1], 1'b1);
        checks++;
        if (core_h_in !== h1) begin
            errors++;
            $display("FAIL two_block_h_in: got %h required %h", core_h_in, h1);
        end
        checks++;
        if (o_block_cnt !== 16'd1) begin
            errors++;
            $display("FAIL two_block_mid_cnt: got %0d required 1", o_block_cnt);
        end
        wait_digest(TWO_DIGEST, 2, "two_block", waited);
    endtask

    task automatic run_timeout(input string name);
        int rise;
        rise = -1;
        set_string("abc");
        build_blocks();
        send_block(msg_q[0], 1'b1);
        for (int i = 1; i <= TO + 5; i++) begin
            @(negedge clk);
            if (o_error && rise < 0) rise = i;
        end
        // WAIT is entered one cycle after the load cycle; ERR follows TO WAIT cycles
        checks++;
        if (rise !== TO + 1) begin
            errors++;
            $display("FAIL %s_error_time: o_error rose %0d cycles after load required %0d", name, rise, TO + 1);
        end
        checks++;
        if ({o_error, s_ready} !== 2'b10) begin
            errors++;
            $display("FAIL %s_err_state: error/ready=%b%b required 10", name, o_error, s_ready);
        end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        checks++;
        if ({o_error, s_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s_abort_clear: error/ready=%b%b required 01", name, o_error, s_ready);
        end
        $display("timeout %s: error after %0d cycles, cleared by abort", name, rise);
    endtask

    task automatic test_timeout();
        model_enable = 1'b0;
        run_timeout("no_core");
        model_enable = 1'b1;
    endtask

    task automatic test_boundary_latency();
        int waited;
        set_string("abc");
        build_blocks();
        model_lat = TO;
        send_message();
        wait_digest(ABC_DIGEST, 1, "lat_edge", waited);
        model_lat = TO + 1;
        run_timeout("lat_late");
        model_lat = 66;
    endtask

    task automatic test_backpressure();
        logic [255:0] held;
        bit ok;
        ok = 1'b0;
        o_digest_ready = 1'b0;
        set_string("abc");
        build_blocks();
        send_message();
        for (int i = 0; i < 1000; i++) begin
            if (o_digest_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_valid: o_digest_valid never rose");
        end
        held = o_digest;
        checks++;
        if (held !== ABC_DIGEST) begin
            errors++;
            $display("FAIL bp_digest: got %h required %h", held, ABC_DIGEST);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({o_digest_valid, s_ready} !== 2'b10 || o_digest !== held) begin
                errors++;
                $display("FAIL bp_hold%0d: valid/ready=%b%b digest=%h required 10 %h",
                         i, o_digest_valid, s_ready, o_digest, held);
            end
            @(negedge clk);
        end
        o_digest_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_digest_valid, s_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: valid/ready=%b%b required 01", o_digest_valid, s_ready);
        end
        $display("backpressure: digest held 20 cycles, idle after ready");
    endtask

    task automatic test_abort();
        int waited;
        logic [255:0] h_before;
        set_string("abc");
        build_blocks();
        send_message();
        repeat (10) @(negedge clk);
        h_before = o_digest;
        model_flush = 1'b1;
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        @(negedge clk);
        model_flush = 1'b0;
        manual_out = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        manual_valid = 1'b1;
        @(negedge clk);
        manual_valid = 1'b0;
        @(negedge clk);
        check_idle_clean("abort_stray", h_before);

        // abort and core_valid together in WAIT: abort must win
        send_message();
        repeat (10) @(negedge clk);
        model_flush = 1'b1;
        manual_valid = 1'b1;
        i_abort = 1'b1;
        @(negedge clk);
        manual_valid = 1'b0;
        i_abort = 1'b0;
        @(negedge clk);
        model_flush = 1'b0;
        check_idle_clean("abort_prio", IV);

        send_message();
        wait_digest(ABC_DIGEST, 1, "after_abort", waited);
    endtask

    task automatic test_reset_midop();
        int waited;
        set_string("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        build_blocks();
        send_block(msg_q[0], 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_clean("midop_in_reset", IV);
        rst_n = 1'b1;
        // the model's stale result arrives while the DUT is idle
        repeat (70) @(negedge clk);
        check_idle_clean("midop_stale", IV);
        set_string("abc");
        build_blocks();
        send_message();
        wait_digest(ABC_DIGEST, 1, "after_reset", waited);
    endtask

    task automatic test_random_messages();
        int waited;
        int len;
        logic [255:0] exp;
        for (int n = 0; n < 4; n++) begin
            len = $urandom_range(0, 130);
            msg_bytes.delete();
            for (int i = 0; i < len; i++) msg_bytes.push_back(8'($urandom));
            build_blocks();
            exp = ref_digest();
            model_lat = $urandom_range(1, TO);
            send_message();
            wait_digest(exp, msg_q.size(), $sformatf("rand%0d_len%0d_lat%0d", n, len, model_lat), waited);
        end
        model_lat = 66;
    endtask

    initial begin
        test_reset();
        test_abc();
        test_two_block();
        test_timeout();
        test_boundary_latency();
        test_backpressure();
        test_abort();
        test_reset_midop();
        test_random_messages();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_block_sequencer.md
SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the hash word width (all buses scale from it).
REQ-002 SHALL have parameter TIMEOUT, default 128, meaning the maximum number of WAIT cycles allowed before core_valid.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port s_valid, input, 1 bit: a message block is offered.
REQ-006 SHALL have port s_ready, output, 1 bit: the sequencer accepts a block.
REQ-007 SHALL have port s_block, input, 16*DATA_WIDTH bits: padded block; word 0 is in the MSBs.
REQ-008 SHALL have port s_last, input, 1 bit: the offered block is the final block of the message.
REQ-009 SHALL have port i_abort, input, 1 bit: abandon the current message and clear the error.
REQ-010 SHALL have port core_load, output, 1 bit: start pulse to the compression core.
REQ-011 SHALL have port core_msg, output, 16*DATA_WIDTH bits: words message0..15, with message0 in the MSBs.
REQ-012 SHALL have port core_h_in, output, 8*DATA_WIDTH bits: chaining value i_0..i_7, with i_0 in the MSBs.
REQ-013 SHALL have port core_h_out, input, 8*DATA_WIDTH bits: the core's final working variables a..h (o_0..o_7), not yet added to the chaining value.
REQ-014 SHALL have port core_valid, input, 1 bit: core_h_out is valid.
REQ-015 SHALL have port o_digest, output, 8*DATA_WIDTH bits: final hash, with H0 in the MSBs.
REQ-016 SHALL have port o_digest_valid, output, 1 bit: o_digest is valid.
REQ-017 SHALL have port o_digest_ready, input, 1 bit: the consumer accepts the digest.
REQ-018 SHALL have port o_block_cnt, output, 16 bits: number of blocks absorbed in the current message.
REQ-019 SHALL have port o_error, output, 1 bit: sticky core-timeout flag.

Function
REQ-020 SHALL implement the FSM states IDLE, LOAD, WAIT, ACC, DONE and ERR.
REQ-021 In IDLE, s_ready SHALL be 1; in every other state s_ready SHALL be 0.
- On s_valid&&s_ready: register s_block and s_last, go to LOAD.
- If first_flag=1, the H register SHALL be set to the FIPS 180-4 IV (6a09e667 .. 5be0cd19).
REQ-022 In LOAD, core_load SHALL be 1 for exactly one cycle, with core_msg = registered block and core_h_in = H; next state WAIT, with the timer cleared to 0.
REQ-023 In WAIT, the timer SHALL increment each cycle.
- If core_valid=1: go to ACC and latch core_h_out.
- Else if timer == TIMEOUT-1: go to ERR.
REQ-024 In ACC (one cycle), the sequencer SHALL perform:
- H[k] <= H[k] + latched_out[k] mod 2^DATA_WIDTH for k = 0..7, carries discarded per word.
- o_block_cnt increment, wrapping 0xFFFF -> 0x0000.
- first_flag <= 0.
- Next state DONE if the registered last = 1, else IDLE.
REQ-025 In DONE, o_digest_valid SHALL be 1 and o_digest SHALL equal H, held stable until o_digest_ready=1; then go to IDLE with first_flag <= 1.
REQ-026 In ERR, o_error SHALL be 1 and s_ready 0; the FSM SHALL remain in ERR until i_abort or reset.
REQ-027 On i_abort=1 in any state, the sequencer SHALL go to IDLE next cycle with first_flag <= 1, o_error <= 0, o_block_cnt <= 0 and o_digest_valid <= 0.
- i_abort SHALL take priority over every other event in the same cycle, including core_valid and o_digest_ready.
REQ-028 A block accepted with first_flag=1 SHALL clear o_block_cnt to 0 before counting.
REQ-029 core_valid outside WAIT SHALL be ignored, with no state or H change.
REQ-030 core_valid arriving in the same cycle the timer reaches TIMEOUT-1 SHALL be honoured, going to ACC rather than ERR.
REQ-031 core_load SHALL be 0 in every state except LOAD.
REQ-032 o_digest SHALL equal H in all states; o_digest is meaningful only while o_digest_valid=1.
REQ-033 Latency from block acceptance to core_load SHALL be 1 cycle.
REQ-034 Latency from core_valid to ACC update SHALL be 1 cycle; on a last block, o_digest_valid SHALL rise 1 cycle after ACC.

Reset
REQ-035 While rst_n=0 at a clock edge, the sequencer SHALL enter IDLE with:
- first_flag=1 and H=IV.
- s_ready=1.
- core_load=0, o_digest_valid=0, o_error=0, o_block_cnt=0, timer=0.
REQ-036 A reset asserted mid-operation (LOAD, WAIT, ACC or DONE) SHALL discard all partial state.
- Any core_valid arriving after reset release SHALL be ignored, per REQ-029.

Verification
REQ-037 The bench SHALL drive a single padded "abc" block with s_last=1, using a behavioural core model with 66-cycle latency.
- Required: o_digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad and o_block_cnt=1.
REQ-038 The bench SHALL drive the two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq".
- Required: core_h_in for block 2 equals H after block 1.
- Required: o_digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1 and o_block_cnt=2.
REQ-039 The bench SHALL run a timeout case: the core model never asserts core_valid.
- Required: o_error=1 exactly TIMEOUT cycles after the WAIT entry and s_ready=0.
- Required: i_abort clears o_error and returns s_ready=1.
REQ-040 The bench SHALL run a backpressure case with o_digest_ready held 0 for 20 cycles in DONE.
- Required: o_digest stable and o_digest_valid=1 throughout, s_ready=0, and IDLE one cycle after ready.
REQ-041 The bench SHALL assert i_abort in WAIT, then pulse core_valid.
- Required: no H change and o_block_cnt=0.
- Required: the next "abc" message still produces ba7816bf...f20015ad.
REQ-042 The bench SHALL assert rst_n=0 during WAIT of block 1 of a two-block message, followed by a fresh "abc" message.
- Required: all outputs at their reset values and a correct "abc" digest.
